// File: rtl/reg_bank_arbiter.sv
// Two-port arbiter with a sequenced access cycle for a small register bank, plus sweep clear.
// Define REG_ARB_RR_EN for round-robin arbitration; the default is fixed priority to port 0.
module reg_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int AW    = 2,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             oe,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             sweep_req,
  output logic [1:0]       gnt,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             sweep_done
);

  if (NREG != 2**AW) begin : g_bad_nreg
    $error("reg_bank_arbiter: NREG must equal 2**AW");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    SWEEP
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bank_q [NREG];
  logic [WIDTH-1:0] rdata_q;
  logic [1:0]       gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             pick0;

`ifdef REG_ARB_RR_EN
  // rr_last_q holds the index of the port granted last
  logic rr_last_q, rr_last_d;

  assign pick0 = req0 & (~req1 | rr_last_q);
`else
  assign pick0 = req0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
`ifdef REG_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pend_q | sweep_req) begin
          state_d = SWEEP;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (req0 | req1) begin
          state_d = ACCESS;
          gnt_d   = pick0 ? 2'b01 : 2'b10;
          we_d    = pick0 ? we0 : we1;
          addr_d  = pick0 ? addr0 : addr1;
          wdata_d = pick0 ? wdata0 : wdata1;
`ifdef REG_ARB_RR_EN
          rr_last_d = ~pick0;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (sweep_req) pend_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        if (sweep_req) pend_d = 1'b1;
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
`ifdef REG_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
`ifdef REG_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ACCESS) begin
        if (we_q) bank_q[addr_q] <= wdata_q;
        else      rdata_q        <= bank_q[addr_q];
      end
      if (state_q == SWEEP) bank_q[idx_q] <= '0;
    end
  end

  assign gnt        = gnt_q;
  assign ack0       = (state_q == RESP) & gnt_q[0];
  assign ack1       = (state_q == RESP) & gnt_q[1];
  assign busy       = (state_q != IDLE);
  assign sweep_done = (state_q == SWEEP) & (idx_q == LAST);
  assign rdata      = oe ? rdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: expected acks queued at drive time,
// popped by a monitor on each ack.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       oe  = 1'b1;
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [1:0] addr0 = 0, addr1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0;
  logic       sweep_req = 0;
  logic [1:0] gnt;
  logic       ack0, ack1, busy, sweep_done;
  logic [3:0] rdata;

  typedef struct packed {
    logic       p;
    logic       rd;
    logic [3:0] d;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] mdl[4];
  int         n_tot = 0;
  int         n_bad = 0;

  reg_bank_arbiter #(.WIDTH(4), .AW(2), .NREG(4)) dut (
    .clk(clk), .clr(clr), .oe(oe),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .sweep_req(sweep_req), .gnt(gnt), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr && (ack0 || ack1)) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {ack1, ack0}, 2'b00);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("ack_port", {ack1, ack0}, e.p ? 2'b10 : 2'b01);
        chk("ack_gnt", gnt, e.p ? 2'b10 : 2'b01);
        if (e.rd) chk("rdata", rdata, e.d);
      end
    end
  end

  function automatic logic ackp(input logic p);
    return p ? ack1 : ack0;
  endfunction

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [1:0] a, input logic [3:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic push(input logic p, input logic w, input logic [1:0] a,
                      input logic [3:0] d);
    sb_t e;
    if (w) mdl[a] = d;
    e.p  = p;
    e.rd = ~w;
    e.d  = w ? 4'h0 : mdl[a];
    sb.push_back(e);
  endtask

  // single access from idle, with grant and latency checks
  task automatic do_acc(input logic p, input logic w, input logic [1:0] a,
                        input logic [3:0] d);
    int cyc;
    @(negedge clk);
    push(p, w, a, d);
    drive(p, 1'b1, w, a, d);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("gnt", gnt, p ? 2'b10 : 2'b01);
      if (ackp(p)) break;
    end
    drive(p, 1'b0, 1'b0, 2'd0, 4'd0);
    chk("latency", cyc, 2);
    @(negedge clk);
    chk("ack_pulse", ackp(p), 1'b0);
  endtask

  task automatic clr_mdl();
    for (int i = 0; i < 4; i++) mdl[i] = 4'h0;
  endtask

  initial begin
    int   acks, nb, sd_at, sd_n;
    logic sd, a0, got;
    sb_t  e;
    clr_mdl();
    #3;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_sdone", sweep_done, 1'b0);
    chk("rst_rdata", rdata, 4'h0);
    @(negedge clk);
    clr = 1'b0;

    // write by port 0, read back by port 1
    do_acc(1'b0, 1'b1, 2'd2, 4'hA);
    do_acc(1'b1, 1'b0, 2'd2, 4'h0);
    chk("raw_rdata", rdata, 4'hA);

    // both ports held high
    do_acc(1'b0, 1'b1, 2'd0, 4'h3);
    do_acc(1'b1, 1'b1, 2'd1, 4'h6);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
`ifdef REG_ARB_RR_EN
      e.p = i[0];
`else
      e.p = 1'b0;
`endif
      e.rd = 1'b1;
      e.d  = e.p ? mdl[1] : mdl[0];
      sb.push_back(e);
    end
    req0 = 1; we0 = 0; addr0 = 2'd0;
    req1 = 1; we1 = 0; addr1 = 2'd1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    req0 = 0; req1 = 0;
    chk("hold_acks", acks, 4);
    repeat (3) @(negedge clk);

    // sweep
    do_acc(1'b0, 1'b1, 2'd0, 4'h1);
    do_acc(1'b0, 1'b1, 2'd1, 4'h2);
    do_acc(1'b0, 1'b1, 2'd2, 4'h3);
    do_acc(1'b0, 1'b1, 2'd3, 4'h4);
    do_acc(1'b1, 1'b0, 2'd2, 4'h0);
    @(negedge clk);
    sweep_req = 1;
    nb = 0; sd_at = 0; sd_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sweep_req = 0;
      if (busy) nb++;
      if (sweep_done) begin
        sd_at = nb;
        sd_n++;
      end
    end
    chk("sweep_busy", nb, 4);
    chk("sweep_done_at", sd_at, 4);
    chk("sweep_done_n", sd_n, 1);
    chk("sweep_keeps_rdata", rdata, 4'h3);
    clr_mdl();
    for (int i = 0; i < 4; i++) do_acc(1'b1, 1'b0, i[1:0], 4'h0);

    // sweep requested during ACCESS
    @(negedge clk);
    push(1'b0, 1'b1, 2'd1, 4'h5);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 4'h5);
    @(negedge clk);
    chk("in_access", busy, 1'b1);
    sweep_req = 1;
    clr_mdl();
    push(1'b1, 1'b0, 2'd1, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    sd = 0; a0 = 0; got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sweep_req = 0;
      if (ack0) begin
        a0 = 1;
        req0 = 0;
      end
      if (sweep_done) begin
        sd = 1;
        chk("ack0_before_sweep", a0, 1'b1);
      end
      if (ack1) begin
        got = 1;
        req1 = 0;
        chk("sweep_before_req1", sd, 1'b1);
        break;
      end
    end
    chk("req1_served", got, 1'b1);
    repeat (2) @(negedge clk);

    // async reset in the middle of ACCESS
    do_acc(1'b0, 1'b1, 2'd3, 4'h9);
    do_acc(1'b1, 1'b0, 2'd3, 4'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 4'h7);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_gnt", gnt, 2'b00);
    chk("clr_busy", busy, 1'b0);
    chk("clr_rdata", rdata, 4'h0);
    chk("clr_ack", ack1, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    @(negedge clk);
    clr = 1'b0;
    clr_mdl();
    repeat (3) @(negedge clk);
    do_acc(1'b0, 1'b0, 2'd3, 4'h0);
    do_acc(1'b1, 1'b0, 2'd0, 4'h0);

    // output enable
    do_acc(1'b0, 1'b1, 2'd2, 4'hC);
    do_acc(1'b1, 1'b0, 2'd2, 4'h0);
    @(negedge clk);
    oe = 1'b0;
    #1;
    chk("oe_off_hidden", rdata === 4'hC, 1'b0);
    chk("oe_off_busy", busy, 1'b0);
    @(negedge clk);
    oe = 1'b1;
    #1;
    chk("oe_on_rdata", rdata, 4'hC);
    chk("oe_gnt", gnt, 2'b00);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
